// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // True when a header word count does not fit in a memory of 2^aw words.
  function automatic logic count_too_big(input logic [15:0] n, input int aw);
    return 32'(n) > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; flags the 4th byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic [1:0]  o_byte_idx
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  // Shift accepted bytes in and count position within the current word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 24'd0;
      r_idx   <= 2'd0;
    end else if (i_clear) begin
      r_shift <= 24'd0;
      r_idx   <= 2'd0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // The last byte completes the word combinationally so the top can register it.
  assign o_word_valid = i_byte_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {r_shift, i_byte};
  assign o_byte_idx   = r_idx;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory and
// keeps the CPU in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  state_e                r_state;
  state_e                w_state_next;
  logic [7:0]            r_cnt_hi;
  logic [15:0]           r_last_idx;
  logic [15:0]           r_word_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_im_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accepting;
  logic                  w_xfer;
  logic [15:0]           w_count;
  logic                  w_too_big;
  logic                  w_load_byte;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic [1:0]            w_byte_idx;
  logic                  w_last_word;

  assign w_accepting = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) || (r_state == ST_LOAD);
  // reload wins over a simultaneous byte: the byte is simply not taken.
  assign in_ready    = w_accepting && !reload;
  assign w_xfer      = in_valid && in_ready;
  assign w_count     = {r_cnt_hi, in_data};
  assign w_too_big   = count_too_big(w_count, ADDR_WIDTH);
  assign w_load_byte = w_xfer && (r_state == ST_LOAD);
  assign w_last_word = w_word_valid && (r_word_idx == r_last_idx);

  word_assembler u_asm (
    .clk          (clk),
    .rst          (reset),
    .i_clear      (reload),
    .i_byte_valid (w_load_byte),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_byte_idx   (w_byte_idx)
  );

  // Next-state decision for header parsing, payload loading and terminal states.
  always_comb begin
    w_state_next = r_state;
    if (reload) begin
      w_state_next = ST_HDR_HI;
    end else begin
      case (r_state)
        ST_HDR_HI: begin
          if (w_xfer) w_state_next = ST_HDR_LO;
          else        w_state_next = ST_HDR_HI;
        end
        ST_HDR_LO: begin
          if (!w_xfer)                w_state_next = ST_HDR_LO;
          else if (w_count == 16'd0)  w_state_next = ST_DONE;
          else if (w_too_big)         w_state_next = ST_ERR;
          else                        w_state_next = ST_LOAD;
        end
        ST_LOAD: begin
          if (w_last_word) w_state_next = ST_DONE;
          else             w_state_next = ST_LOAD;
        end
        ST_DONE: w_state_next = ST_DONE;
        ST_ERR:  w_state_next = ST_ERR;
        default: w_state_next = ST_HDR_HI;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_HDR_HI;
    else       r_state <= w_state_next;
  end

  // Header capture and word/address counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_hi   <= 8'd0;
      r_last_idx <= 16'd0;
      r_word_idx <= 16'd0;
      r_addr     <= '0;
    end else if (reload) begin
      r_word_idx <= 16'd0;
      r_addr     <= '0;
    end else begin
      if ((r_state == ST_HDR_HI) && w_xfer) r_cnt_hi <= in_data;
      if ((r_state == ST_HDR_LO) && w_xfer) begin
        r_last_idx <= w_count - 16'd1;
        r_word_idx <= 16'd0;
        r_addr     <= '0;
      end
      if (w_word_valid) begin
        r_word_idx <= r_word_idx + 16'd1;
        r_addr     <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered memory write port: one-cycle strobe, address/data hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_im_addr <= '0;
      r_wdata   <= 32'd0;
    end else begin
      r_we <= w_word_valid;
      if (w_word_valid) begin
        r_im_addr <= r_addr;
        r_wdata   <= w_word;
      end
    end
  end

  // Status flags; cpu_reset trails done by one edge so memory is settled first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else if (reload) begin
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_cpu_reset <= ~r_done;
      if ((r_state == ST_HDR_HI || r_state == ST_HDR_LO || r_state == ST_LOAD) &&
          (w_state_next == ST_DONE)) r_done <= 1'b1;
      if ((r_state == ST_HDR_LO) && (w_state_next == ST_ERR)) r_error <= 1'b1;
    end
  end

  assign im_we     = r_we;
  assign im_addr   = r_im_addr;
  assign im_wdata  = r_wdata;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int AW  = 7;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          reload;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // observed write log
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc;
  int          crst_cyc;
  logic        p_done = 1'b0;
  logic        p_crst = 1'b1;

  // expected results
  logic [7:0]  stream[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (im_we === 1'b1) begin
      got_addr.push_back(int'(im_addr));
      got_data.push_back(im_wdata);
      got_cyc.push_back(cyc);
    end
    if (done === 1'b1 && p_done === 1'b0 && done_cyc < 0) done_cyc = cyc;
    if (cpu_reset === 1'b0 && p_crst === 1'b1 && crst_cyc < 0) crst_cyc = cyc;
    p_done = done;
    p_crst = cpu_reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    done_cyc = -1;
    crst_cyc = -1;
  endtask

  function automatic void push_hdr(input int n);
    stream.push_back(8'(n / 256));
    stream.push_back(8'(n % 256));
  endfunction

  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) stream.push_back(8'((w >> (8 * b)) & 32'hFF));
  endfunction

  // Reference: parse the byte stream by its format rules.
  function automatic void build_expect();
    int n;
    logic [31:0] w;
    n = int'(stream[0]) * 256 + int'(stream[1]);
    exp_err  = (n > CAP);
    exp_done = !exp_err;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w = 32'(stream[2 + 4 * i]) * 32'd16777216 + 32'(stream[3 + 4 * i]) * 32'd65536
          + 32'(stream[4 + 4 * i]) * 32'd256 + 32'(stream[5 + 4 * i]);
        exp_addr.push_back(i);
        exp_data.push_back(w);
      end
    end
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int gap_after, input int gap_len, input bit rnd);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i]);
      if (i == gap_after) idle(gap_len);
      if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    int m;
    chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
      chk({tag, "_data"}, got_data[i], exp_data[i]);
    end
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  initial begin
    int c0;
    int n;
    reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    done_cyc = -1; crst_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // N=2 at full rate
    clear_log(); stream.delete();
    push_hdr(2); push_word(32'h20100200); push_word(32'h2008FFFF);
    build_expect();
    c0 = cyc;
    run_stream(-1, 0, 1'b0);
    compare_writes("n2");
    for (int i = 0; i < got_cyc.size(); i++) chk("n2_we_cycle", 32'(got_cyc[i]), 32'(c0 + 7 + 4 * i));
    chk("n2_done_cycle", 32'(done_cyc), 32'(c0 + 11));
    chk("n2_crst_cycle", 32'(crst_cyc), 32'(c0 + 12));
    chk("n2_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // same image with a 3-cycle gap after the 2nd payload byte
    do_reload();
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    clear_log();
    build_expect();
    c0 = cyc;
    run_stream(3, 3, 1'b0);
    compare_writes("gap");
    for (int i = 0; i < got_cyc.size(); i++) chk("gap_we_cycle", 32'(got_cyc[i]), 32'(c0 + 10 + 4 * i));
    chk("gap_crst_cycle", 32'(crst_cyc), 32'(c0 + 15));

    // N=0
    do_reload(); clear_log(); stream.delete();
    push_hdr(0); build_expect();
    c0 = cyc;
    run_stream(-1, 0, 1'b0);
    compare_writes("n0");
    chk("n0_done_cycle", 32'(done_cyc), 32'(c0 + 3));
    chk("n0_crst_cycle", 32'(crst_cyc), 32'(c0 + 4));
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("n0_in_ready", {31'd0, in_ready}, 32'd0);
    end
    #1 in_valid = 1'b0;
    chk("n0_no_extra_write", 32'(got_addr.size()), 32'd0);

    // N over capacity, then recovery with N=1
    do_reload(); clear_log(); stream.delete();
    push_hdr(CAP + 1); build_expect();
    run_stream(-1, 0, 1'b0);
    compare_writes("big");
    chk("big_in_ready", {31'd0, in_ready}, 32'd0);
    chk("big_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    do_reload();
    chk("big_reload_error", {31'd0, error}, 32'd0);
    clear_log(); stream.delete();
    push_hdr(1); push_word($urandom()); build_expect();
    run_stream(-1, 0, 1'b0);
    compare_writes("after_big");

    // reload colliding with the 3rd byte of word 1
    do_reload(); clear_log(); stream.delete();
    push_hdr(2); push_word(32'hCAFEF00D); push_word(32'h11223344);
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    reload = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk);
    chk("collide_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reload = 1'b0; in_valid = 1'b0;
    idle(3);
    chk("collide_nwrites", 32'(got_addr.size()), 32'd1);
    stream.delete();
    push_hdr(1); push_word(32'hA5A55A5A);
    run_stream(-1, 0, 1'b0);
    exp_addr.push_back(0); exp_data.push_back(32'hCAFEF00D);
    exp_addr.push_back(0); exp_data.push_back(32'hA5A55A5A);
    exp_done = 1'b1; exp_err = 1'b0;
    compare_writes("collide");

    // async reset right after the first word's final byte
    do_reload(); clear_log(); stream.delete();
    push_hdr(2); push_word(32'hDEADBEEF);
    for (int i = 0; i < 6; i++) send_byte(stream[i]);
    reset = 1'b1;
    #1;
    chk("arst_im_we", {31'd0, im_we}, 32'd0);
    chk("arst_im_addr", 32'(im_addr), 32'd0);
    chk("arst_im_wdata", im_wdata, 32'd0);
    chk("arst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_no_write", 32'(got_addr.size()), 32'd0);
    clear_log(); stream.delete();
    push_hdr(3); for (int i = 0; i < 3; i++) push_word($urandom());
    build_expect();
    run_stream(-1, 0, 1'b0);
    compare_writes("after_arst");

    // randomized images, first one at full capacity
    for (int it = 0; it < 6; it++) begin
      do_reload(); clear_log(); stream.delete();
      n = (it == 0) ? CAP : $urandom_range(1, 10);
      push_hdr(n);
      for (int i = 0; i < n; i++) push_word($urandom());
      build_expect();
      run_stream(-1, 0, 1'b1);
      compare_writes("rand");
      if (got_cyc.size() > 0) begin
        chk("rand_done_cycle", 32'(done_cyc), 32'(got_cyc[got_cyc.size() - 1]));
        chk("rand_crst_cycle", 32'(crst_cyc), 32'(got_cyc[got_cyc.size() - 1] + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
